// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding and counter sizing.
package mult_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Step counter must hold 0..WIDTH-1 with one spare bit so it never wraps mid-op.
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/ripple_adder_w.sv
// WIDTH-bit combinational ripple-carry adder; per-cycle datapath of the multiplier.
module ripple_adder_w #(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH:0] carry;

   always_comb begin
      sum      = '0;
      carry    = '0;
      carry[0] = cin;
      for (int i = 0; i < int'(WIDTH); i++) begin
         sum[i]     = a[i] ^ b[i] ^ carry[i];
         carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
      cout = carry[WIDTH];
   end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier with valid/ready handshakes.
// Optional MULT_ZERO_BYPASS_EN: zero operands skip the RUN phase and finish with product 0.
module shift_add_mult
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product
);

   localparam int unsigned CW = cnt_width(WIDTH);
   localparam int unsigned PW = 2 * WIDTH;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [PW-1:0]    product_q, product_d;

   logic [WIDTH-1:0] add_sum;
   logic             add_cout;
   logic [WIDTH-1:0] hi_n_c;
   logic             carry_c;
   logic [WIDTH-1:0] hi_step_c;
   logic [WIDTH-1:0] lo_step_c;

   ripple_adder_w #(.WIDTH(WIDTH)) u_adder (
      .a    (hi_q),
      .b    (mcand_q),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Add the multiplicand only when the current multiplier bit is set, then shift {c,hi,lo} right.
   always_comb begin
      hi_n_c    = hi_q;
      carry_c   = 1'b0;
      if (lo_q[0]) begin
         hi_n_c  = add_sum;
         carry_c = add_cout;
      end
      hi_step_c = {carry_c, hi_n_c[WIDTH-1:1]};
      lo_step_c = {hi_n_c[0], lo_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d     = state_q;
      mcand_d     = mcand_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      cnt_d       = cnt_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      product_d   = product_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               mcand_d    = a;
               lo_d       = b;
               hi_d       = '0;
               cnt_d      = '0;
               in_ready_d = 1'b0;
               state_d    = S_RUN;
`ifdef MULT_ZERO_BYPASS_EN
               if ((a == '0) || (b == '0)) begin
                  product_d = '0;
                  state_d   = S_DONE;
               end
`endif
            end
         end
         S_RUN: begin
            hi_d  = hi_step_c;
            lo_d  = lo_step_c;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               product_d   = {hi_step_c, lo_step_c};
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            // On the bypass path out_valid rises one cycle after entering DONE.
            out_valid_d = 1'b1;
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         mcand_q     <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         product_q   <= '0;
      end else begin
         state_q     <= state_d;
         mcand_q     <= mcand_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         product_q   <= product_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign product   = product_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult: vector table, handshake corner cases, random back-to-back ops.
module tb_shift_add_mult;

   localparam int W = 4;
`ifdef MULT_ZERO_BYPASS_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = W;
`endif

   logic           clk;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] product;

   int n_tests;
   int n_fail;
   int cyc;
   logic [2*W-1:0] exp_q[$];

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] prod;
      int             lat;
   } vec_t;

   vec_t vecs[8];

   shift_add_mult #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Scoreboard: compare each completed output handshake against the oldest expected product.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected output", 32'(product), 32'hFFFF_FFFF);
         end else begin
            check("product", 32'(product), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [2*W-1:0] ep,
                        input int exp_lat, input string nm, output int acc_cyc);
      int k;
      int lat;
      k = 0;
      while (!in_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      acc_cyc = cyc;
      if (!in_ready) begin
         check({nm, " in_ready timeout"}, 32'd0, 32'd1);
         return;
      end
      a        = ia;
      b        = ib;
      in_valid = 1'b1;
      exp_q.push_back(ep);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      acc_cyc  = cyc;
      lat = 0;
      @(negedge clk);
      while (!out_valid && lat < 100) begin
         lat++;
         @(negedge clk);
      end
      check({nm, " latency"}, 32'(lat), 32'(exp_lat));
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (out_valid && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (out_valid) check("out_valid drop timeout", 32'd1, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int prev_acc;
      logic [W-1:0]   ra;
      logic [W-1:0]   rb;
      logic [2*W-1:0] ep;

      n_tests   = 0;
      n_fail    = 0;
      cyc       = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;

      vecs[0] = '{a: 4'd7, b: 4'd3, prod: 8'd21,  lat: W};
      vecs[1] = '{a: 4'hF, b: 4'hF, prod: 8'hE1,  lat: W};
      vecs[2] = '{a: 4'd0, b: 4'd9, prod: 8'd0,   lat: ZLAT};
      vecs[3] = '{a: 4'd9, b: 4'd0, prod: 8'd0,   lat: ZLAT};
      vecs[4] = '{a: 4'd1, b: 4'd1, prod: 8'd1,   lat: W};
      vecs[5] = '{a: 4'hF, b: 4'd1, prod: 8'd15,  lat: W};
      vecs[6] = '{a: 4'd8, b: 4'd8, prod: 8'd64,  lat: W};
      vecs[7] = '{a: 4'd12, b: 4'd11, prod: 8'd132, lat: W};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset product", 32'(product), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Table vectors with out_ready held high
      for (int i = 0; i < 8; i++) begin
         issue(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].lat, $sformatf("vec%0d", i), acc);
         wait_idle();
      end

      // Back-pressure: product and flags held while out_ready is low; in_valid ignored
      out_ready = 1'b0;
      issue(4'd5, 4'd6, 8'd30, W, "hold", acc);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold out_valid", 32'(out_valid), 32'd1);
         check("hold product", 32'(product), 32'd30);
         check("hold in_ready", 32'(in_ready), 32'd0);
         in_valid = ~in_valid;
         a        = W'($urandom);
         b        = W'($urandom);
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      wait_idle();
      check("hold queue drained", 32'(exp_q.size()), 32'd0);

      // Asynchronous reset in the middle of RUN
      @(negedge clk);
      a        = 4'd13;
      b        = 4'd11;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort out_valid", 32'(out_valid), 32'd0);
      check("abort product", 32'(product), 32'd0);
      check("abort in_ready", 32'(in_ready), 32'd1);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(4'd9, 4'd9, 8'd81, W, "post_reset", acc);
      wait_idle();

      // Random back-to-back ops; accepts must be WIDTH+2 cycles apart
      prev_acc = 0;
      for (int i = 0; i < 500; i++) begin
         ra = W'($urandom_range(1, 15));
         rb = W'($urandom_range(1, 15));
         ep = {4'b0, ra} * {4'b0, rb};
         issue(ra, rb, ep, W, "rand", acc);
         if (i > 0) check("accept spacing", 32'(acc - prev_acc), 32'(W + 2));
         prev_acc = acc;
      end
      wait_idle();
      check("final queue drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
